bootcode_trace_monitor: RTL and testbench

- Synthesizable, multi-channel successor to the simulation-only bootcode logger.
- Watches NUM_CH boot engines, each with a PostCode and a PC bus, and detects value changes.
- Timestamps each change and queues it in a trace FIFO that a debug/readout agent drains over a valid/ready handshake.
- Flags error postcodes (upper byte >= ERR_THRESH) in hardware, with a sticky first-error record and a halt request.

---
 rtl/bootcode_trace_pkg.sv | 39 +++
 rtl/bootcode_trace_fifo.sv | 66 ++++++
 rtl/bootcode_trace_monitor.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_bootcode_trace_monitor.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bootcode_trace_pkg.sv
// Shared types, default configuration values and width helpers for the
// multi-channel boot-code trace monitor.
package bootcode_trace_pkg;

    // Kind of change that produced a trace entry.
    typedef enum logic {
        EV_POST = 1'b0,
        EV_PC   = 1'b1
    } ev_type_e;

    // Postcode buses are always this wide.
    localparam int POST_WIDTH = 32;

    // Default configuration.
    localparam int         DEF_NUM_CH     = 2;
    localparam int         DEF_PC_WIDTH   = 32;
    localparam int         DEF_DEPTH      = 16;
    localparam int         DEF_TS_WIDTH   = 24;
    localparam logic [7:0] DEF_ERR_THRESH = 8'hF0;

    // A trace entry carries a postcode or a PC. Its data field is as wide as
    // the wider of the two.
    function automatic int data_w(input int pc_width);
        return (pc_width > POST_WIDTH) ? pc_width : POST_WIDTH;
    endfunction

    localparam int DEF_CH_W   = (DEF_NUM_CH > 1) ? $clog2(DEF_NUM_CH) : 1;
    localparam int DEF_DATA_W = data_w(DEF_PC_WIDTH);

    // Entry layout for the default configuration. The top level builds the
    // same field order at its own parameter widths: {ch, type, data, ts}.
    typedef struct packed {
        logic [DEF_CH_W-1:0]     ch;
        ev_type_e                typ;
        logic [DEF_DATA_W-1:0]   data;
        logic [DEF_TS_WIDTH-1:0] ts;
    } trace_entry_t;

endpackage

// File: rtl/bootcode_trace_fifo.sv
// First-word-fall-through FIFO. The head entry is visible on o_rdata whenever
// o_empty is low. Push into a full FIFO is accepted only when a pop happens
// on the same edge; pop on an empty FIFO is ignored.
module bootcode_trace_fifo
    import bootcode_trace_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == LVL_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bootcode_trace_monitor.sv
// Multi-channel boot trace monitor. Each channel has a postcode source and a
// PC source. A change on an enabled, primed source is timestamped and parked
// in that source's one-entry pending slot. A round-robin arbiter moves one
// slot per cycle into the trace FIFO. Error postcodes set a sticky first-error
// record that also drives a halt request.
module bootcode_trace_monitor
    import bootcode_trace_pkg::*;
#(
    parameter  int         NUM_CH     = DEF_NUM_CH,
    parameter  int         PC_WIDTH   = DEF_PC_WIDTH,
    parameter  int         DEPTH      = DEF_DEPTH,
    parameter  int         TS_WIDTH   = DEF_TS_WIDTH,
    parameter  logic [7:0] ERR_THRESH = DEF_ERR_THRESH,
    localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int         DATA_W     = data_w(PC_WIDTH),
    localparam int         LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_CH-1:0]          ChEn,
    input  logic [NUM_CH*32-1:0]       PostCode,
    input  logic [NUM_CH*PC_WIDTH-1:0] PC,
    output logic                       TraceValid,
    input  logic                       TraceReady,
    output logic [CH_W-1:0]            TraceCh,
    output logic                       TraceType,
    output logic [DATA_W-1:0]          TraceData,
    output logic [TS_WIDTH-1:0]        TraceTime,
    output logic [LVL_W-1:0]           Level,
    output logic [15:0]                DropCnt,
    input  logic                       ErrClr,
    output logic                       ErrFlag,
    output logic [CH_W-1:0]            ErrCh,
    output logic [31:0]                ErrCode,
    output logic                       HaltReq
);

    // Sources are interleaved per channel: post0, pc0, post1, pc1, ...
    // so source index = 2*channel + type.
    localparam int NSRC  = 2 * NUM_CH;
    localparam int SRC_W = $clog2(NSRC);
    localparam int CNT_W = SRC_W + 1;

    typedef struct packed {
        logic [CH_W-1:0]     ch;
        ev_type_e            typ;
        logic [DATA_W-1:0]   data;
        logic [TS_WIDTH-1:0] ts;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Registered state.
    logic [TS_WIDTH-1:0] r_ts;
    logic [NUM_CH-1:0]   r_primed;
    logic [31:0]         r_prev_post [NUM_CH];
    logic [PC_WIDTH-1:0] r_prev_pc   [NUM_CH];
    logic [NSRC-1:0]     r_slot_vld;
    logic [DATA_W-1:0]   r_slot_data [NSRC];
    logic [TS_WIDTH-1:0] r_slot_ts   [NSRC];
    logic [SRC_W-1:0]    r_ptr;
    logic [15:0]         r_drop_cnt;
    logic                r_err_flag;
    logic                r_halt;
    logic [CH_W-1:0]     r_err_ch;
    logic [31:0]         r_err_code;

    // Combinational signals.
    logic [31:0]         w_cur_post [NUM_CH];
    logic [PC_WIDTH-1:0] w_cur_pc   [NUM_CH];
    logic [NSRC-1:0]     w_ev;
    logic [DATA_W-1:0]   w_ev_data  [NSRC];
    logic [NSRC-1:0]     w_load;
    logic [NSRC-1:0]     w_drop;
    logic [CNT_W-1:0]    w_drop_n;
    logic [16:0]         w_drop_sum;
    logic                w_err_any;
    logic [CH_W-1:0]     w_err_ch;
    logic [31:0]         w_err_code;
    logic                w_gnt_vld;
    logic [SRC_W-1:0]    w_gnt_idx;
    logic [NSRC-1:0]     w_gnt_sel;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_can_push;
    entry_t              w_wentry;
    entry_t              w_rentry;
    logic [ENTRY_W-1:0]  w_rdata;
    logic [LVL_W-1:0]    w_level;

    // Unpack the channel buses and flag sources whose value moved since the last enabled cycle.
    always_comb begin
        w_ev = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_cur_post[c] = PostCode[c*32 +: 32];
            w_cur_pc[c]   = PC[c*PC_WIDTH +: PC_WIDTH];

            w_ev_data[2*c]                       = '0;
            w_ev_data[2*c][31:0]                 = w_cur_post[c];
            w_ev_data[2*c+1]                     = '0;
            w_ev_data[2*c+1][PC_WIDTH-1:0]       = w_cur_pc[c];

            w_ev[2*c]   = ChEn[c] && r_primed[c] && (w_cur_post[c] != r_prev_post[c]);
            w_ev[2*c+1] = ChEn[c] && r_primed[c] && (w_cur_pc[c]   != r_prev_pc[c]);
        end
    end

    // First-error candidate this cycle; the lowest channel wins a tie.
    always_comb begin
        w_err_any  = 1'b0;
        w_err_ch   = '0;
        w_err_code = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_ev[2*c] && (w_cur_post[c][31:24] >= ERR_THRESH)) begin
                w_err_any  = 1'b1;
                w_err_ch   = CH_W'(c);
                w_err_code = w_cur_post[c];
            end
        end
    end

    // FIFO can take an entry when it has room or the head leaves this cycle.
    assign w_pop      = !w_empty && TraceReady;
    assign w_can_push = !w_full || w_pop;

    // Round-robin search starting at r_ptr for the first pending slot.
    always_comb begin
        logic [SRC_W:0] v_sum;
        logic [SRC_W-1:0] v_idx;
        v_sum     = '0;
        v_idx     = '0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_gnt_sel = '0;
        if (w_can_push) begin
            for (int k = 0; k < NSRC; k++) begin
                v_sum = {1'b0, r_ptr} + (SRC_W+1)'(k);
                if (v_sum >= (SRC_W+1)'(NSRC)) begin
                    v_sum = v_sum - (SRC_W+1)'(NSRC);
                end
                v_idx = v_sum[SRC_W-1:0];
                if (!w_gnt_vld && r_slot_vld[v_idx]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = v_idx;
                end
            end
        end
        if (w_gnt_vld) begin
            w_gnt_sel[w_gnt_idx] = 1'b1;
        end
    end

    // A new event fills a slot that is empty or being drained this edge; otherwise it is lost.
    always_comb begin
        w_load   = '0;
        w_drop   = '0;
        w_drop_n = '0;
        for (int s = 0; s < NSRC; s++) begin
            w_load[s] = w_ev[s] && (!r_slot_vld[s] || w_gnt_sel[s]);
            w_drop[s] = w_ev[s] && r_slot_vld[s] && !w_gnt_sel[s];
            w_drop_n  = w_drop_n + CNT_W'(w_drop[s]);
        end
        w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_n);
    end

    // Build the FIFO entry from the granted slot; channel and type come from its index.
    always_comb begin
        w_wentry.ch   = CH_W'(w_gnt_idx >> 1);
        w_wentry.typ  = ev_type_e'(w_gnt_idx[0]);
        w_wentry.data = r_slot_data[w_gnt_idx];
        w_wentry.ts   = r_slot_ts[w_gnt_idx];
    end

    bootcode_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_push  (w_gnt_vld),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign w_rentry = w_rdata;

    // Head fields are forced to zero while the FIFO is empty.
    assign TraceValid = !w_empty;
    assign TraceCh    = w_empty ? '0 : w_rentry.ch;
    assign TraceType  = !w_empty && (w_rentry.typ == EV_PC);
    assign TraceData  = w_empty ? '0 : w_rentry.data;
    assign TraceTime  = w_empty ? '0 : w_rentry.ts;
    assign Level      = w_level;
    assign DropCnt    = r_drop_cnt;
    assign ErrFlag    = r_err_flag;
    assign ErrCh      = r_err_ch;
    assign ErrCode    = r_err_code;
    assign HaltReq    = r_halt;

    // Free-running timestamp; wraps silently.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Track previous values while enabled; the first enabled cycle only primes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_primed <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_prev_post[c] <= '0;
                r_prev_pc[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ChEn[c]) begin
                    r_primed[c]    <= 1'b1;
                    r_prev_post[c] <= w_cur_post[c];
                    r_prev_pc[c]   <= w_cur_pc[c];
                end else begin
                    r_primed[c]    <= 1'b0;
                end
            end
        end
    end

    // Pending-slot occupancy: refill beats drain when both happen on one edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_slot_vld <= '0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                if (w_load[s]) begin
                    r_slot_vld[s] <= 1'b1;
                end else if (w_gnt_sel[s]) begin
                    r_slot_vld[s] <= 1'b0;
                end
            end
        end
    end

    // Pending-slot payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge Clk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (w_load[s]) begin
                r_slot_data[s] <= w_ev_data[s];
                r_slot_ts[s]   <= r_ts;
            end
        end
    end

    // Arbiter pointer moves past the winner; drop counter saturates.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ptr      <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_gnt_vld) begin
                r_ptr <= (w_gnt_idx == SRC_W'(NSRC - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    // Sticky first-error record; a fresh error outranks a simultaneous clear.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_err_flag <= 1'b0;
            r_halt     <= 1'b0;
            r_err_ch   <= '0;
            r_err_code <= '0;
        end else if (w_err_any && (!r_err_flag || ErrClr)) begin
            r_err_flag <= 1'b1;
            r_halt     <= 1'b1;
            r_err_ch   <= w_err_ch;
            r_err_code <= w_err_code;
        end else if (ErrClr) begin
            r_err_flag <= 1'b0;
            r_halt     <= 1'b0;
            r_err_ch   <= '0;
            r_err_code <= '0;
        end
    end

endmodule

// File: tb/tb_bootcode_trace_monitor.sv
// Directed bench for bootcode_trace_monitor: two channels, 32-bit PCs,
// 4-entry trace FIFO.
module tb_bootcode_trace_monitor;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  ChEn;
    logic [63:0] PostCode;
    logic [63:0] PC;
    logic        TraceValid;
    logic        TraceReady;
    logic        TraceCh;
    logic        TraceType;
    logic [31:0] TraceData;
    logic [23:0] TraceTime;
    logic [2:0]  Level;
    logic [15:0] DropCnt;
    logic        ErrClr;
    logic        ErrFlag;
    logic        ErrCh;
    logic [31:0] ErrCode;
    logic        HaltReq;

    int n_vec = 0;
    int n_err = 0;

    // Reference cycle count since reset, used as the expected timestamp.
    logic [23:0] tb_ts;
    logic [23:0] t0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (Reset) tb_ts <= '0;
        else       tb_ts <= tb_ts + 24'd1;
    end

    bootcode_trace_monitor #(
        .NUM_CH     (2),
        .PC_WIDTH   (32),
        .DEPTH      (4),
        .TS_WIDTH   (24),
        .ERR_THRESH (8'hF0)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ChEn       (ChEn),
        .PostCode   (PostCode),
        .PC         (PC),
        .TraceValid (TraceValid),
        .TraceReady (TraceReady),
        .TraceCh    (TraceCh),
        .TraceType  (TraceType),
        .TraceData  (TraceData),
        .TraceTime  (TraceTime),
        .Level      (Level),
        .DropCnt    (DropCnt),
        .ErrClr     (ErrClr),
        .ErrFlag    (ErrFlag),
        .ErrCh      (ErrCh),
        .ErrCode    (ErrCode),
        .HaltReq    (HaltReq)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; ChEn = 2'b00; PostCode = '0; PC = '0;
        TraceReady = 1'b0; ErrClr = 1'b0;
        tick(); tick();
        n_vec++;
        if ({TraceValid, TraceCh, TraceType, TraceData, TraceTime, Level, DropCnt,
             ErrFlag, ErrCh, ErrCode, HaltReq} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b lvl=%0d drop=%0d err=%b code=%h halt=%b required all zero",
                     TraceValid, Level, DropCnt, ErrFlag, ErrCode, HaltReq);
        end
        Reset = 1'b0;
    endtask

    task automatic test_simultaneous();
        ChEn = 2'b11; PostCode = '0;
        PC[31:0] = 32'hFFFF_0000; PC[63:32] = 32'h0000_1000; TraceReady = 1'b1;
        tick();
        PostCode[31:0] = 32'h0000_0011; PostCode[63:32] = 32'h0000_0022; t0 = tb_ts;
        tick(); tick();
        n_vec++;
        if ({TraceValid, TraceCh, TraceType, TraceData, TraceTime} !== {1'b1, 1'b0, 1'b0, 32'h11, t0}) begin
            n_err++;
            $display("FAIL pair1_first: got v=%b ch=%b t=%b d=%h ts=%h required 1 0 0 00000011 %h",
                     TraceValid, TraceCh, TraceType, TraceData, TraceTime, t0);
        end
        tick();
        n_vec++;
        if ({TraceValid, TraceCh, TraceType, TraceData, TraceTime} !== {1'b1, 1'b1, 1'b0, 32'h22, t0}) begin
            n_err++;
            $display("FAIL pair1_second: got v=%b ch=%b t=%b d=%h ts=%h required 1 1 0 00000022 %h",
                     TraceValid, TraceCh, TraceType, TraceData, TraceTime, t0);
        end
        tick();
        n_vec++;
        if ({TraceValid, Level} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL pair1_drained: got v=%b lvl=%0d required 0 0", TraceValid, Level);
        end
        // Pointer now sits at pc1, so pc1 beats post0 despite the lower index.
        PC[63:32] = 32'h0000_1004; PostCode[31:0] = 32'h0000_0033; t0 = tb_ts;
        tick(); tick();
        n_vec++;
        if ({TraceValid, TraceCh, TraceType, TraceData, TraceTime} !== {1'b1, 1'b1, 1'b1, 32'h1004, t0}) begin
            n_err++;
            $display("FAIL pair2_first: got v=%b ch=%b t=%b d=%h ts=%h required 1 1 1 00001004 %h",
                     TraceValid, TraceCh, TraceType, TraceData, TraceTime, t0);
        end
        tick();
        n_vec++;
        if ({TraceValid, TraceCh, TraceType, TraceData, TraceTime} !== {1'b1, 1'b0, 1'b0, 32'h33, t0}) begin
            n_err++;
            $display("FAIL pair2_second: got v=%b ch=%b t=%b d=%h ts=%h required 1 0 0 00000033 %h",
                     TraceValid, TraceCh, TraceType, TraceData, TraceTime, t0);
        end
        tick();
    endtask

    task automatic test_pc_latency();
        PC[31:0] = 32'hFFFF_0004; t0 = tb_ts;
        tick();
        n_vec++;
        if ({TraceValid, Level} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL latency_early: got v=%b lvl=%0d required 0 0", TraceValid, Level);
        end
        tick();
        n_vec++;
        if ({TraceValid, TraceCh, TraceType, TraceData, TraceTime, Level} !==
            {1'b1, 1'b0, 1'b1, 32'hFFFF_0004, t0, 3'd1}) begin
            n_err++;
            $display("FAIL latency_entry: got v=%b ch=%b t=%b d=%h ts=%h lvl=%0d required 1 0 1 ffff0004 %h 1",
                     TraceValid, TraceCh, TraceType, TraceData, TraceTime, Level, t0);
        end
        tick();
        n_vec++;
        if ({TraceValid, Level} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL latency_drained: got v=%b lvl=%0d required 0 0", TraceValid, Level);
        end
    endtask

    task automatic test_overflow();
        logic [2:0] exp_lvl [5];
        exp_lvl = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd1};
        TraceReady = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            PC[31:0] = 32'hFFFF_0004 + 32'(4 * i);
            if (i == 1) t0 = tb_ts;
            tick();
        end
        n_vec++;
        if ({Level, DropCnt, TraceData, TraceTime} !== {3'd4, 16'd2, 32'hFFFF_0008, t0}) begin
            n_err++;
            $display("FAIL overflow_state: got lvl=%0d drop=%0d head=%h ts=%h required 4 2 ffff0008 %h",
                     Level, DropCnt, TraceData, TraceTime, t0);
        end
        TraceReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({TraceValid, TraceData, Level} !== {1'b1, 32'hFFFF_0008 + 32'(4 * i), exp_lvl[i]}) begin
                n_err++;
                $display("FAIL overflow_drain%0d: got v=%b d=%h lvl=%0d required 1 %h %0d",
                         i, TraceValid, TraceData, Level, 32'hFFFF_0008 + 32'(4 * i), exp_lvl[i]);
            end
            tick();
        end
        n_vec++;
        if ({TraceValid, Level} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL overflow_empty: got v=%b lvl=%0d required 0 0", TraceValid, Level);
        end
    endtask

    task automatic test_error();
        PostCode[63:32] = 32'hF100_0001;
        tick();
        n_vec++;
        if ({ErrFlag, ErrCh, ErrCode, HaltReq} !== {1'b1, 1'b1, 32'hF100_0001, 1'b1}) begin
            n_err++;
            $display("FAIL err_first: got f=%b ch=%b code=%h halt=%b required 1 1 f1000001 1",
                     ErrFlag, ErrCh, ErrCode, HaltReq);
        end
        PostCode[63:32] = 32'hF200_0002;
        tick();
        n_vec++;
        if ({ErrFlag, ErrCh, ErrCode, TraceValid, TraceCh, TraceType, TraceData} !==
            {1'b1, 1'b1, 32'hF100_0001, 1'b1, 1'b1, 1'b0, 32'hF100_0001}) begin
            n_err++;
            $display("FAIL err_sticky: got f=%b ch=%b code=%h head v=%b ch=%b t=%b d=%h required 1 1 f1000001 1 1 0 f1000001",
                     ErrFlag, ErrCh, ErrCode, TraceValid, TraceCh, TraceType, TraceData);
        end
        ErrClr = 1'b1; PostCode[63:32] = 32'hF300_0003;
        tick();
        ErrClr = 1'b0;
        n_vec++;
        if ({ErrFlag, ErrCh, ErrCode, HaltReq} !== {1'b1, 1'b1, 32'hF300_0003, 1'b1}) begin
            n_err++;
            $display("FAIL err_clr_race: got f=%b ch=%b code=%h halt=%b required 1 1 f3000003 1",
                     ErrFlag, ErrCh, ErrCode, HaltReq);
        end
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        n_vec++;
        if ({ErrFlag, ErrCh, ErrCode, HaltReq} !== '0) begin
            n_err++;
            $display("FAIL err_clear: got f=%b ch=%b code=%h halt=%b required 0 0 00000000 0",
                     ErrFlag, ErrCh, ErrCode, HaltReq);
        end
        PostCode[31:0] = 32'hEFFF_FFFF;
        tick();
        n_vec++;
        if ({ErrFlag, HaltReq} !== 2'b00) begin
            n_err++;
            $display("FAIL err_below_thresh: got f=%b halt=%b required 0 0", ErrFlag, HaltReq);
        end
        PostCode[31:0] = 32'hF000_0000;
        tick();
        n_vec++;
        if ({ErrFlag, ErrCh, ErrCode, HaltReq} !== {1'b1, 1'b0, 32'hF000_0000, 1'b1}) begin
            n_err++;
            $display("FAIL err_at_thresh: got f=%b ch=%b code=%h halt=%b required 1 0 f0000000 1",
                     ErrFlag, ErrCh, ErrCode, HaltReq);
        end
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        tick(); tick(); tick();
        n_vec++;
        if ({TraceValid, Level, ErrFlag} !== {1'b0, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL err_drained: got v=%b lvl=%0d f=%b required 0 0 0", TraceValid, Level, ErrFlag);
        end
    endtask

    task automatic test_chen_toggle();
        ChEn = 2'b10;
        tick();
        PC[31:0] = 32'h2000_0000;
        tick();
        ChEn = 2'b11;
        tick(); tick();
        n_vec++;
        if ({TraceValid, Level} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL chen_prime: got v=%b lvl=%0d d=%h required 0 0", TraceValid, Level, TraceData);
        end
        PC[31:0] = 32'h2000_0010; t0 = tb_ts;
        tick(); tick();
        n_vec++;
        if ({TraceValid, TraceCh, TraceType, TraceData, TraceTime} !== {1'b1, 1'b0, 1'b1, 32'h2000_0010, t0}) begin
            n_err++;
            $display("FAIL chen_next: got v=%b ch=%b t=%b d=%h ts=%h required 1 0 1 20000010 %h",
                     TraceValid, TraceCh, TraceType, TraceData, TraceTime, t0);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        TraceReady = 1'b0;
        PostCode[31:0] = 32'hF500_0000;
        tick(); tick();
        for (int i = 1; i <= 3; i++) begin
            PC[31:0] = 32'h3000_0000 + 32'(i);
            tick();
        end
        n_vec++;
        if ({Level, ErrFlag, DropCnt} !== {3'd3, 1'b1, 16'd2}) begin
            n_err++;
            $display("FAIL midflight_setup: got lvl=%0d f=%b drop=%0d required 3 1 2", Level, ErrFlag, DropCnt);
        end
        Reset = 1'b1; PC[31:0] = 32'h4000_0000;
        tick();
        n_vec++;
        if ({TraceValid, TraceCh, TraceType, TraceData, TraceTime, Level, DropCnt,
             ErrFlag, ErrCh, ErrCode, HaltReq} !== '0) begin
            n_err++;
            $display("FAIL midflight_reset: got valid=%b lvl=%0d drop=%0d err=%b code=%h halt=%b required all zero",
                     TraceValid, Level, DropCnt, ErrFlag, ErrCode, HaltReq);
        end
        Reset = 1'b0; PC[31:0] = 32'h4000_0004;
        tick(); tick(); tick();
        n_vec++;
        if ({TraceValid, Level} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL midflight_prime: got v=%b lvl=%0d required 0 0", TraceValid, Level);
        end
        PC[31:0] = 32'h4000_0008; t0 = tb_ts;
        tick(); tick();
        n_vec++;
        if ({TraceValid, TraceCh, TraceType, TraceData, TraceTime} !== {1'b1, 1'b0, 1'b1, 32'h4000_0008, 24'd3}) begin
            n_err++;
            $display("FAIL midflight_first: got v=%b ch=%b t=%b d=%h ts=%h required 1 0 1 40000008 000003 (model %h)",
                     TraceValid, TraceCh, TraceType, TraceData, TraceTime, t0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_simultaneous();
        test_pc_latency();
        test_overflow();
        test_error();
        test_chen_toggle();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
